// File: rtl/front_panel_pkg.sv
// Shared types and constants for the front-panel input conditioner.
package front_panel_pkg;

   localparam int unsigned NUM_KEYS            = 10;
   localparam int unsigned NUM_SW              = 4;
   localparam int unsigned NUM_IN              = NUM_KEYS + NUM_SW;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 50000;
   localparam int unsigned POP_W               = $clog2(NUM_KEYS + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LOCKED  = 2'd2
   } key_state_t;

   // Number of keys currently asserted in a debounced key vector.
   function automatic logic [POP_W-1:0] popcount(input logic [NUM_KEYS-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         n = n + POP_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/front_panel_conditioner_debounce_cell.sv
// Two-flop synchroniser followed by a restart-on-mismatch debounce counter.
module debounce_cell
   import front_panel_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
   parameter logic        RST_VAL         = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic raw,
   output logic stable
);

   logic             sync1;
   logic             sync2;
   logic [CNT_W-1:0] cnt;

   // Bring the asynchronous raw level into the clk domain.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1 <= RST_VAL;
         sync2 <= RST_VAL;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Flip the stable level only after DEBOUNCE_CYCLES consecutive mismatching samples.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stable <= RST_VAL;
         cnt    <= '0;
      end else if (sync2 == stable) begin
         cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
         stable <= sync2;
         cnt    <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/front_panel_conditioner.sv
// Synchronises, debounces and validates front-panel keys and switches for the controller.
module front_panel_conditioner
   import front_panel_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic [NUM_KEYS-1:0] key_raw,
   input  logic                start_raw,
   input  logic                stop_raw,
   input  logic                clear_raw,
   input  logic                door_raw,
   output logic [NUM_KEYS-1:0] keyboard,
   output logic                key_strobe,
   output logic                startn,
   output logic                stopn,
   output logic                clearn,
   output logic                door_closed
);

   logic [NUM_IN-1:0]   raw_all;
   logic [NUM_IN-1:0]   stable_all;
   logic [NUM_KEYS-1:0] kd;
   logic [POP_W-1:0]    kd_count;

   key_state_t          state_q;
   key_state_t          state_d;
   logic [NUM_KEYS-1:0] keyboard_d;
   logic                key_strobe_d;

   assign raw_all  = {door_raw, clear_raw, stop_raw, start_raw, key_raw};
   assign kd       = stable_all[NUM_KEYS-1:0];
   assign kd_count = popcount(kd);

   // One debounce cell per raw input; all reset to 0 (door reads open).
   for (genvar i = 0; i < NUM_IN; i++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W),
         .RST_VAL         (1'b0)
      ) u_cell (
         .clk    (clk),
         .resetn (resetn),
         .raw    (raw_all[i]),
         .stable (stable_all[i])
      );
   end

   // Key FSM state and registered key outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         keyboard   <= '0;
         key_strobe <= 1'b0;
      end else begin
         state_q    <= state_d;
         keyboard   <= keyboard_d;
         key_strobe <= key_strobe_d;
      end
   end

   // Key FSM: accept a single key, lock out on rollover until full release.
   always_comb begin
      state_d      = state_q;
      keyboard_d   = '0;
      key_strobe_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (kd_count == POP_W'(1)) begin
               state_d      = PRESSED;
               keyboard_d   = kd;
               key_strobe_d = 1'b1;
            end else if (kd_count > POP_W'(1)) begin
               state_d = LOCKED;
            end
         end
         PRESSED: begin
            if (kd == keyboard) begin
               keyboard_d = keyboard;
            end else if (kd == '0) begin
               state_d = IDLE;
            end else begin
               state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (kd == '0) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Registered button and door levels; buttons are active-low toward the controller.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         startn      <= 1'b1;
         stopn       <= 1'b1;
         clearn      <= 1'b1;
         door_closed <= 1'b0;
      end else begin
         startn      <= ~stable_all[NUM_KEYS];
         stopn       <= ~stable_all[NUM_KEYS+1];
         clearn      <= ~stable_all[NUM_KEYS+2];
         door_closed <= stable_all[NUM_KEYS+3];
      end
   end

endmodule

// File: tb/tb_front_panel_conditioner.sv
// Directed bench for front_panel_conditioner with DEBOUNCE_CYCLES = 4 (accept latency 7 edges).
module tb_front_panel_conditioner;

   logic       clk;
   logic       resetn;
   logic [9:0] key_raw;
   logic       start_raw;
   logic       stop_raw;
   logic       clear_raw;
   logic       door_raw;
   logic [9:0] keyboard;
   logic       key_strobe;
   logic       startn;
   logic       stopn;
   logic       clearn;
   logic       door_closed;

   int n_cmp;
   int n_err;

   front_panel_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .key_raw     (key_raw),
      .start_raw   (start_raw),
      .stop_raw    (stop_raw),
      .clear_raw   (clear_raw),
      .door_raw    (door_raw),
      .keyboard    (keyboard),
      .key_strobe  (key_strobe),
      .startn      (startn),
      .stopn       (stopn),
      .clearn      (clearn),
      .door_closed (door_closed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and land 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      key_raw = '0; start_raw = 0; stop_raw = 0; clear_raw = 0; door_raw = 0;
      settle(3);
      if ({keyboard, key_strobe, startn, stopn, clearn, door_closed} !== {10'h000, 1'b0, 4'b1110}) begin
         n_err++;
         $display("FAIL reset_hold: got kb=%h st=%b sn=%b pn=%b cn=%b dc=%b want 000 0 1 1 1 0",
                  keyboard, key_strobe, startn, stopn, clearn, door_closed);
      end
      n_cmp++;
      resetn = 1'b1;
      start_raw = 1'b1;
      settle(8);
      if (startn !== 1'b0) begin
         n_err++; $display("FAIL reset_pre_start: got %b want 0", startn);
      end
      n_cmp++;
      // assert reset between edges: outputs must clear without a clock
      #2 resetn = 1'b0;
      #1;
      if ({keyboard, key_strobe, startn, stopn, clearn, door_closed} !== {10'h000, 1'b0, 4'b1110}) begin
         n_err++;
         $display("FAIL reset_async: got kb=%h st=%b sn=%b pn=%b cn=%b dc=%b want 000 0 1 1 1 0",
                  keyboard, key_strobe, startn, stopn, clearn, door_closed);
      end
      n_cmp++;
      start_raw = 1'b0;
      settle(2);
      resetn = 1'b1;
      settle(2);
   endtask

   task automatic test_press_release();
      key_raw = 10'h008;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (keyboard !== ((e >= 7) ? 10'h008 : 10'h000)) begin
            n_err++; $display("FAIL press_kb edge %0d: got %h want %h", e, keyboard, (e >= 7) ? 10'h008 : 10'h000);
         end
         n_cmp++;
         if (key_strobe !== (e == 7)) begin
            n_err++; $display("FAIL press_strobe edge %0d: got %b want %b", e, key_strobe, e == 7);
         end
         n_cmp++;
      end
      key_raw = 10'h000;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (keyboard !== ((e >= 7) ? 10'h000 : 10'h008)) begin
            n_err++; $display("FAIL release_kb edge %0d: got %h want %h", e, keyboard, (e >= 7) ? 10'h000 : 10'h008);
         end
         n_cmp++;
      end
      settle(2);
   endtask

   task automatic test_bounce();
      // 1,1,0,0,1,1,0,0 then steady 1; final rise applied after edge 8
      for (int j = 0; j < 20; j++) begin
         start_raw = (j >= 8) ? 1'b1 : (((j / 2) % 2) == 0);
         step();
         if (startn !== ((j + 1 >= 15) ? 1'b0 : 1'b1)) begin
            n_err++; $display("FAIL bounce_startn edge %0d: got %b want %b", j + 1, startn, (j + 1 >= 15) ? 1'b0 : 1'b1);
         end
         n_cmp++;
      end
      start_raw = 1'b0;
      settle(8);
      if (startn !== 1'b1) begin
         n_err++; $display("FAIL bounce_release: got %b want 1", startn);
      end
      n_cmp++;
   endtask

   task automatic test_buttons();
      start_raw = 1'b1; stop_raw = 1'b1;
      settle(7);
      if ({startn, stopn, clearn} !== 3'b001) begin
         n_err++; $display("FAIL start_stop_both: got %b want 001", {startn, stopn, clearn});
      end
      n_cmp++;
      start_raw = 1'b0; stop_raw = 1'b0; clear_raw = 1'b1;
      settle(7);
      if ({startn, stopn, clearn} !== 3'b110) begin
         n_err++; $display("FAIL clear_only: got %b want 110", {startn, stopn, clearn});
      end
      n_cmp++;
      clear_raw = 1'b0;
      settle(8);
   endtask

   task automatic test_rollover();
      int strobes;
      key_raw = 10'h008;
      settle(8);
      if (keyboard !== 10'h008) begin
         n_err++; $display("FAIL roll_first: got %h want 008", keyboard);
      end
      n_cmp++;
      key_raw = 10'h028;
      for (int e = 1; e <= 9; e++) begin
         step();
         if (keyboard !== ((e >= 7) ? 10'h000 : 10'h008)) begin
            n_err++; $display("FAIL roll_add_kb edge %0d: got %h want %h", e, keyboard, (e >= 7) ? 10'h000 : 10'h008);
         end
         n_cmp++;
         if (key_strobe !== 1'b0) begin
            n_err++; $display("FAIL roll_add_strobe edge %0d: got %b want 0", e, key_strobe);
         end
         n_cmp++;
      end
      key_raw = 10'h020;
      for (int e = 1; e <= 10; e++) begin
         step();
         if ({keyboard, key_strobe} !== 11'h000) begin
            n_err++; $display("FAIL roll_partial edge %0d: got kb=%h st=%b want 000 0", e, keyboard, key_strobe);
         end
         n_cmp++;
      end
      key_raw = 10'h000;
      settle(10);
      key_raw = 10'h020;
      strobes = 0;
      for (int e = 1; e <= 10; e++) begin
         step();
         if (key_strobe === 1'b1) strobes++;
      end
      if (keyboard !== 10'h020) begin
         n_err++; $display("FAIL roll_new_kb: got %h want 020", keyboard);
      end
      n_cmp++;
      if (strobes !== 1) begin
         n_err++; $display("FAIL roll_new_strobes: got %0d want 1", strobes);
      end
      n_cmp++;
      key_raw = 10'h000;
      settle(10);
   endtask

   task automatic test_simultaneous();
      key_raw = 10'h006;
      for (int e = 1; e <= 12; e++) begin
         step();
         if ({keyboard, key_strobe} !== 11'h000) begin
            n_err++; $display("FAIL simul_held edge %0d: got kb=%h st=%b want 000 0", e, keyboard, key_strobe);
         end
         n_cmp++;
      end
      key_raw = 10'h000;
      for (int e = 1; e <= 10; e++) begin
         step();
         if ({keyboard, key_strobe} !== 11'h000) begin
            n_err++; $display("FAIL simul_release edge %0d: got kb=%h st=%b want 000 0", e, keyboard, key_strobe);
         end
         n_cmp++;
      end
   endtask

   task automatic test_door_reset();
      door_raw = 1'b1;
      for (int e = 1; e <= 8; e++) begin
         step();
         if (door_closed !== (e >= 7)) begin
            n_err++; $display("FAIL door edge %0d: got %b want %b", e, door_closed, e >= 7);
         end
         n_cmp++;
      end
      key_raw = 10'h200;
      settle(8);
      if (keyboard !== 10'h200) begin
         n_err++; $display("FAIL door_key9: got %h want 200", keyboard);
      end
      n_cmp++;
      #2 resetn = 1'b0;
      #1;
      if ({keyboard, key_strobe, startn, stopn, clearn, door_closed} !== {10'h000, 1'b0, 4'b1110}) begin
         n_err++;
         $display("FAIL midpress_reset: got kb=%h st=%b sn=%b pn=%b cn=%b dc=%b want 000 0 1 1 1 0",
                  keyboard, key_strobe, startn, stopn, clearn, door_closed);
      end
      n_cmp++;
      settle(2);
      resetn = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         step();
         if (keyboard !== ((e >= 7) ? 10'h200 : 10'h000)) begin
            n_err++; $display("FAIL rekey_kb edge %0d: got %h want %h", e, keyboard, (e >= 7) ? 10'h200 : 10'h000);
         end
         n_cmp++;
         if (key_strobe !== (e == 7)) begin
            n_err++; $display("FAIL rekey_strobe edge %0d: got %b want %b", e, key_strobe, e == 7);
         end
         n_cmp++;
         if (door_closed !== (e >= 7)) begin
            n_err++; $display("FAIL rekey_door edge %0d: got %b want %b", e, door_closed, e >= 7);
         end
         n_cmp++;
      end
      key_raw = 10'h000;
      door_raw = 1'b0;
      settle(10);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_press_release();
      test_bounce();
      test_buttons();
      test_rollover();
      test_simultaneous();
      test_door_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
